// File: rtl/fft_frame_packer_if.sv
// Sample stream from the frame packer to the downstream FFT core.
// Beat = {imag[15:0], real[15:0]}; tlast marks the final beat of a frame.
interface fft_frame_packer_if;
   logic        tvalid;
   logic        tready;
   logic [31:0] tdata;
   logic        tlast;

   modport master (output tvalid, output tdata, output tlast, input tready);
   modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/fft_frame_packer.sv
// Captures one FRAME_LEN-sample frame of 8-bit offset-binary ADC data per fft_en rising
// edge and streams it as signed complex beats through a small FIFO and an output register.
module fft_frame_packer #(
   parameter int unsigned FRAME_LEN  = 1024,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               fft_en,
   input  logic [7:0]         ad_data_in,
   fft_frame_packer_if.master m_axis,
   output logic               busy,
   output logic               frame_done,
   output logic               overflow
);
   localparam int unsigned CntW  = $clog2(FRAME_LEN);
   localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
   localparam int unsigned FillW = PtrW + 1;
   localparam logic [CntW-1:0]  LastIdx = CntW'(FRAME_LEN - 1);
   localparam logic [FillW-1:0] FullCnt = FillW'(FIFO_DEPTH);

   typedef enum logic [1:0] {StIdle, StCapture, StDrain} state_e;

   state_e            state_q, state_d;
   logic              fft_en_q;
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [FillW-1:0]  fill_q, fill_d;
   logic [CntW-1:0]   cap_cnt_q, cap_cnt_d, out_cnt_q, out_cnt_d;
   logic              tvalid_q, tvalid_d;
   logic [15:0]       treal_q, treal_d;
   logic              overflow_q, overflow_d;
   logic              done_q, done_d;
   logic [15:0]       mem_q [FIFO_DEPTH];

   logic [7:0]        sample_tc;
   logic [15:0]       sample_re;
   logic              accept, push, pop, last_beat;

   always_comb begin
      sample_tc  = ad_data_in ^ 8'h80;
      sample_re  = {{8{sample_tc[7]}}, sample_tc};
      accept     = tvalid_q & m_axis.tready;
      last_beat  = accept && (out_cnt_q == LastIdx);
      // The output register refills from the FIFO head whenever it is empty or being drained.
      pop        = (state_q != StIdle) && (fill_q != '0) && (!tvalid_q || accept);
      push       = (state_q == StCapture) && ((fill_q != FullCnt) || pop);

      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      fill_d     = fill_q;
      cap_cnt_d  = cap_cnt_q;
      out_cnt_d  = out_cnt_q;
      tvalid_d   = tvalid_q;
      treal_d    = treal_q;
      overflow_d = overflow_q;
      done_d     = last_beat;

      if (push) begin
         wr_ptr_d  = wr_ptr_q + 1'b1;
         cap_cnt_d = cap_cnt_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         tvalid_d = 1'b1;
         treal_d  = mem_q[rd_ptr_q];
      end else if (accept) begin
         tvalid_d = 1'b0;
      end
      if (accept) begin
         out_cnt_d = out_cnt_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   fill_d = fill_q + 1'b1;
         2'b01:   fill_d = fill_q - 1'b1;
         default: fill_d = fill_q;
      endcase

      case (state_q)
         StIdle: begin
            if (fft_en && !fft_en_q) begin
               state_d    = StCapture;
               wr_ptr_d   = '0;
               rd_ptr_d   = '0;
               fill_d     = '0;
               cap_cnt_d  = '0;
               out_cnt_d  = '0;
               overflow_d = 1'b0;
            end
         end
         StCapture: begin
            if (!push) begin
               overflow_d = 1'b1;
            end
            if (push && (cap_cnt_q == LastIdx)) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (last_beat) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Edge detector resets high so an fft_en held through reset cannot arm a frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         fft_en_q   <= 1'b1;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fill_q     <= '0;
         cap_cnt_q  <= '0;
         out_cnt_q  <= '0;
         tvalid_q   <= 1'b0;
         treal_q    <= '0;
         overflow_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         fft_en_q   <= fft_en;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fill_q     <= fill_d;
         cap_cnt_q  <= cap_cnt_d;
         out_cnt_q  <= out_cnt_d;
         tvalid_q   <= tvalid_d;
         treal_q    <= treal_d;
         overflow_q <= overflow_d;
         done_q     <= done_d;
      end
   end

   // Sample storage needs no reset; occupancy is tracked by fill_q.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= sample_re;
      end
   end

   assign m_axis.tvalid = tvalid_q;
   assign m_axis.tdata  = {16'h0000, treal_q};
   assign m_axis.tlast  = tvalid_q && (out_cnt_q == LastIdx);
   assign busy          = (state_q != StIdle);
   assign frame_done    = done_q;
   assign overflow      = overflow_q;

endmodule

// File: tb/tb_fft_frame_packer.sv
// Scoreboard bench for fft_frame_packer: stimulus queues expected beats, a negedge monitor
// pops and compares every accepted beat and checks outputs hold while stalled.
module tb_fft_frame_packer;
   localparam int unsigned FrameLen  = 16;
   localparam int unsigned FifoDepth = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       fft_en = 1'b0;
   logic [7:0] ad_data_in = 8'h00;
   logic       busy, frame_done, overflow;

   fft_frame_packer_if m_axis ();

   fft_frame_packer #(
      .FRAME_LEN (FrameLen),
      .FIFO_DEPTH(FifoDepth)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .fft_en    (fft_en),
      .ad_data_in(ad_data_in),
      .m_axis    (m_axis),
      .busy      (busy),
      .frame_done(frame_done),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          beats = 0;
   int          done_cnt = 0;
   int          cyc = 0;
   int          bp_mode = 0;
   logic [32:0] exp_q[$];
   logic        prev_stall = 1'b0;
   logic [31:0] prev_data = '0;
   logic        prev_last = 1'b0;
   logic [15:0] pat = 16'b1011_0110_1101_0011;

   task automatic chk(input string name, input logic [33:0] act, input logic [33:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, want);
      end
   endtask

   task automatic exp_push(input logic [15:0] re, input logic last);
      exp_q.push_back({last, 16'h0000, re});
   endtask

   // One clock; tready for the coming cycle follows the active backpressure mode.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      case (bp_mode)
         1:       m_axis.tready = (cyc < 20) ? !((cyc == 6) || (cyc == 10)) : pat[4'(cyc % 16)];
         2:       m_axis.tready = (cyc > 10);
         default: m_axis.tready = 1'b1;
      endcase
   endtask

   task automatic arm();
      fft_en = 1'b0;
      tick();
      fft_en   = 1'b1;
      beats    = 0;
      done_cnt = 0;
      cyc      = 0;
      tick();
   endtask

   task automatic end_frame(input string name, input logic want_ovf);
      int n = 0;
      while (busy && n < 400) begin
         tick();
         n++;
      end
      chk({name, "_timeout"}, 34'(busy), 34'd0);
      tick();
      chk({name, "_beats"}, 34'(beats), 34'(FrameLen));
      chk({name, "_done_pulses"}, 34'(done_cnt), 34'd1);
      chk({name, "_overflow"}, 34'(overflow), 34'(want_ovf));
      chk({name, "_queue_left"}, 34'(exp_q.size()), 34'd0);
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_hold", {m_axis.tvalid, m_axis.tlast, m_axis.tdata},
                {1'b1, prev_last, prev_data});
         end
         if (m_axis.tvalid && m_axis.tready) begin
            beats++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat got %h want none", {m_axis.tlast, m_axis.tdata});
            end else begin
               chk("beat", {1'b0, m_axis.tlast, m_axis.tdata}, {1'b0, exp_q.pop_front()});
            end
         end
         if (frame_done) done_cnt++;
         prev_stall = m_axis.tvalid && !m_axis.tready;
         prev_data  = m_axis.tdata;
         prev_last  = m_axis.tlast;
      end
   end

   initial begin
      m_axis.tready = 1'b1;
      fft_en = 1'b1;
      repeat (3) tick();
      chk("rst_tvalid", 34'(m_axis.tvalid), 34'd0);
      chk("rst_tdata", 34'(m_axis.tdata), 34'd0);
      chk("rst_busy", 34'(busy), 34'd0);
      chk("rst_overflow", 34'(overflow), 34'd0);
      rst_n = 1'b1;
      repeat (5) tick();
      chk("no_start_held_en", 34'(busy), 34'd0);

      // Ramp 80..8F with free-flowing output.
      bp_mode = 0;
      for (int i = 0; i < 16; i++) exp_push(16'(i), i == 15);
      arm();
      chk("arm_busy", 34'(busy), 34'd1);
      for (int k = 0; k < 16; k++) begin
         ad_data_in = 8'h80 + 8'(k);
         tick();
         if (k == 0) chk("latency_low", 34'(m_axis.tvalid), 34'd0);
         if (k == 1) chk("latency_high", 34'(m_axis.tvalid), 34'd1);
      end
      end_frame("ramp", 1'b0);

      // Backpressure plus an fft_en low/high pulse mid-frame.
      bp_mode = 1;
      for (int i = 0; i < 16; i++) exp_push(16'hFF90 + 16'(i), i == 15);
      arm();
      for (int k = 0; k < 16; k++) begin
         ad_data_in = 8'h10 + 8'(k);
         if (k == 5) fft_en = 1'b0;
         if (k == 7) fft_en = 1'b1;
         tick();
      end
      end_frame("backpressure", 1'b0);
      repeat (30) tick();
      chk("no_rearm_busy", 34'(busy), 34'd0);
      chk("no_rearm_done", 34'(done_cnt), 34'd1);

      // Output stalled for 10 cycles: samples drop but the frame still has 16 beats.
      bp_mode = 2;
      ad_data_in = 8'hFF;
      for (int i = 0; i < 16; i++) exp_push(16'h007F, i == 15);
      arm();
      end_frame("overflow", 1'b1);

      // Extremes 00/FF; the arm must clear the sticky overflow.
      bp_mode = 0;
      for (int i = 0; i < 16; i++) exp_push(((i % 2) == 0) ? 16'hFF80 : 16'h007F, i == 15);
      arm();
      chk("overflow_clear", 34'(overflow), 34'd0);
      for (int k = 0; k < 16; k++) begin
         ad_data_in = ((k % 2) == 0) ? 8'h00 : 8'hFF;
         tick();
      end
      end_frame("extremes", 1'b0);

      // Reset mid-frame with fft_en held high.
      for (int i = 0; i < 16; i++) exp_push(16'(i), i == 15);
      arm();
      for (int k = 0; k < 10; k++) begin
         ad_data_in = 8'h80 + 8'(k);
         tick();
      end
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      chk("abort_tvalid", 34'(m_axis.tvalid), 34'd0);
      chk("abort_tlast", 34'(m_axis.tlast), 34'd0);
      chk("abort_tdata", 34'(m_axis.tdata), 34'd0);
      chk("abort_busy", 34'(busy), 34'd0);
      chk("abort_done", 34'(frame_done), 34'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (20) tick();
      chk("post_reset_idle", 34'(busy), 34'd0);
      chk("post_reset_tvalid", 34'(m_axis.tvalid), 34'd0);
      for (int i = 0; i < 16; i++) exp_push(16'(i), i == 15);
      arm();
      for (int k = 0; k < 16; k++) begin
         ad_data_in = 8'h80 + 8'(k);
         tick();
      end
      end_frame("after_reset", 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog expired");
   end
endmodule
